// File: rtl/multi_press_detector.sv
// multi_press_detector: per-channel debounced short/long/auto-repeat button press detector
module multi_press_detector #(
  parameter int NUM_CH        = 4,
  parameter int CLK_PERIOD_ns = 20,
  parameter int DEBOUNCE_ns   = 60,
  parameter int LONG_ns       = 200,
  parameter int REPEAT_ns     = 100,
  parameter int REPEAT_EN     = 1
) (
  input  logic              clk,
  input  logic              reset_sync,
  input  logic              enable,
  input  logic [NUM_CH-1:0] btn,
  output logic [NUM_CH-1:0] short_pulse,
  output logic [NUM_CH-1:0] long_pulse,
  output logic [NUM_CH-1:0] repeat_pulse,
  output logic [NUM_CH-1:0] held
);
  localparam int DB_CNT   = DEBOUNCE_ns / CLK_PERIOD_ns;
  localparam int LONG_CNT = LONG_ns / CLK_PERIOD_ns;
  localparam int REP_CNT  = REPEAT_ns / CLK_PERIOD_ns;
  localparam int MAX_CNT  = LONG_CNT > REP_CNT ? LONG_CNT : REP_CNT;
  localparam int TW       = $clog2(MAX_CNT + 1);
  localparam int DW       = $clog2(DB_CNT + 1);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PRESS = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [1:0]    r_sync;
    logic          r_deb, r_prev, r_short, r_long, r_rep, r_held;
    logic [DW-1:0] r_dcnt;
    logic [1:0]    r_st, w_nst;
    logic [TW-1:0] r_tmr, w_ntmr;
    logic          w_sh, w_lg, w_rp;
    always_comb begin
      w_nst  = r_st;
      w_ntmr = r_tmr + 1'b1;
      w_sh   = 1'b0;
      w_lg   = 1'b0;
      w_rp   = 1'b0;
      if (!enable) begin
        w_nst  = IDLE;
        w_ntmr = '0;
      end else if (r_st == IDLE) begin
        w_nst  = (r_deb && !r_prev) ? PRESS : IDLE;
        w_ntmr = '0;
      end else if (!r_deb) begin
        w_sh   = r_st == PRESS;
        w_nst  = IDLE;
        w_ntmr = '0;
      end else if (r_st == PRESS && r_tmr == TW'(LONG_CNT - 1)) begin
        w_lg   = 1'b1;
        w_nst  = HOLD;
        w_ntmr = '0;
      end else if (r_st == HOLD && REPEAT_EN == 0) begin
        w_ntmr = r_tmr;
      end else if (r_st == HOLD && r_tmr == TW'(REP_CNT - 1)) begin
        w_rp   = 1'b1;
        w_ntmr = '0;
      end
    end
    always_ff @(posedge clk) begin
      if (reset_sync) begin
        r_sync  <= '0;
        r_deb   <= 1'b0;
        r_prev  <= 1'b0;
        r_dcnt  <= '0;
        r_st    <= IDLE;
        r_tmr   <= '0;
        r_short <= 1'b0;
        r_long  <= 1'b0;
        r_rep   <= 1'b0;
        r_held  <= 1'b0;
      end else begin
        r_sync  <= {r_sync[0], btn[g]};
        r_prev  <= r_deb;
        // deb flips only after DB_CNT consecutive disagreeing cycles, same for both edges
        if (r_sync[1] == r_deb) r_dcnt <= '0;
        else if (r_dcnt == DW'(DB_CNT - 1)) begin
          r_deb  <= ~r_deb;
          r_dcnt <= '0;
        end else r_dcnt <= r_dcnt + 1'b1;
        r_st    <= w_nst;
        r_tmr   <= w_ntmr;
        r_short <= w_sh;
        r_long  <= w_lg;
        r_rep   <= w_rp;
        r_held  <= w_nst != IDLE;
      end
    end
    assign short_pulse[g]  = r_short;
    assign long_pulse[g]   = r_long;
    assign repeat_pulse[g] = r_rep;
    assign held[g]         = r_held;
  end
endmodule
